// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared width defaults for the fetch path
package params_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, imem address, instruction register, valid/ready
//
// Purpose: owns the program counter, drives the combinational imem word
// address from the PC register, latches the returned word and hands it to
// decode over a valid/ready handshake. Accepts PC redirects (flush) and halt.
//
// Optional feature macro: FETCH_PERF_EN (adds fetch_cnt_o / stall_cnt_o).
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   en_i                    start/continue fetching from IDLE
//   halt_i                  stop issuing fetches, return to IDLE
//   imem_addr_o/imem_instr_i  imem word address / combinational read data
//   instr_o, pc_o, valid_o  latched instruction, its address, unconsumed flag
//   ready_i                 decode accepts instr_o this cycle
//   redirect_i, redirect_pc_i  load new PC and flush the held instruction
//   fetch_cnt_o, stall_cnt_o   saturating perf counters (FETCH_PERF_EN only)
module fetch_ctrl #(
    parameter int                    ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  halt_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic                  redirect_i,
`ifdef FETCH_PERF_EN
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           stall_cnt_o
`else
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   pco_q, pco_d;
    logic                    valid_q, valid_d;
    logic                    capture;
    logic                    transfer;

    assign transfer    = valid_q && ready_i;
    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign pc_o        = pco_q;
    assign valid_o     = valid_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pco_d   = pco_q;
        valid_d = valid_q;
        capture = 1'b0;

        if (redirect_i) begin
            // A transfer in the same cycle is simply consumed; the flush wins.
            pc_d    = redirect_pc_i;
            valid_d = 1'b0;
            state_d = (halt_i || state_q == ST_IDLE) ? ST_IDLE : ST_FETCH;
        end else if (halt_i && state_q != ST_IDLE) begin
            // An unconsumed instruction survives the halt and waits in IDLE.
            if (transfer) begin
                valid_d = 1'b0;
            end
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (transfer) begin
                        valid_d = 1'b0;
                    end
                    if (en_i && !halt_i && !valid_q) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (transfer) begin
                        capture = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (capture) begin
            instr_d = imem_instr_i;
            pco_d   = pc_q;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pco_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (capture && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (valid_q && !ready_i && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven bench for fetch_ctrl
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_f(input int a);
        if (a == 1) return 32'h4470;
        return 32'(a * 100);
    endfunction

    // main instance, ADDR_WIDTH = 8
    logic        rst, en, halt, ready, redir;
    logic [7:0]  rpc, addr, pco;
    logic [31:0] imem, instr;
    logic        valid;
`ifdef FETCH_PERF_EN
    logic [31:0] fcnt, scnt, s_fcnt, s_scnt;
`endif

    always_comb imem = mem_f(int'(addr));

    fetch_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .halt_i(halt),
        .imem_addr_o(addr), .imem_instr_i(imem),
        .instr_o(instr), .pc_o(pco), .valid_o(valid), .ready_i(ready),
        .redirect_i(redir),
`ifdef FETCH_PERF_EN
        .redirect_pc_i(rpc), .fetch_cnt_o(fcnt), .stall_cnt_o(scnt)
`else
        .redirect_pc_i(rpc)
`endif
    );

    // small instance, ADDR_WIDTH = 4, for PC wrap
    logic        s_rst, s_en, s_halt, s_ready, s_redir;
    logic [3:0]  s_rpc, s_addr, s_pco;
    logic [31:0] s_imem, s_instr;
    logic        s_valid;

    always_comb s_imem = mem_f(int'(s_addr));

    fetch_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut_s (
        .clk_i(clk), .rst_i(s_rst), .en_i(s_en), .halt_i(s_halt),
        .imem_addr_o(s_addr), .imem_instr_i(s_imem),
        .instr_o(s_instr), .pc_o(s_pco), .valid_o(s_valid), .ready_i(s_ready),
        .redirect_i(s_redir),
`ifdef FETCH_PERF_EN
        .redirect_pc_i(s_rpc), .fetch_cnt_o(s_fcnt), .stall_cnt_o(s_scnt)
`else
        .redirect_pc_i(s_rpc)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en, halt, ready, redir;
        logic [7:0]  rpc;
        logic        valid;
        logic [7:0]  pco;
        logic [31:0] instr;
        logic [7:0]  addr;
    } vec_t;

    vec_t vecs[21];

    initial begin
        //              en halt rdy redir rpc   valid pco instr     addr
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 8'd0,  32'd0,    8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 8'd0,  32'd0,    8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 8'd0,  32'd0,    8'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 8'd0,  32'd0,    8'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd0,  32'd0,    8'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd1,  32'h4470, 8'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd2,  32'd200,  8'd3};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd2,  32'd200,  8'd3};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd2,  32'd200,  8'd3};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd2,  32'd200,  8'd3};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd2,  32'd200,  8'd3};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd3,  32'd300,  8'd4};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd4,  32'd400,  8'd5};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd63, 1'b0, 8'd4,  32'd400,  8'd63};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 8'd63, 32'd6300, 8'd64};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd63, 32'd6300, 8'd64};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 8'd63, 32'd6300, 8'd64};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1, 8'd63, 32'd6300, 8'd64};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 8'd63, 32'd6300, 8'd64};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 8'd63, 32'd6300, 8'd64};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 8'd63, 32'd6300, 8'd64};

        rst = 1'b1; en = 1'b0; halt = 1'b0; ready = 1'b0; redir = 1'b0; rpc = '0;
        s_rst = 1'b1; s_en = 1'b0; s_halt = 1'b0; s_ready = 1'b0; s_redir = 1'b0; s_rpc = '0;
        step();
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            en    = vecs[i].en;
            halt  = vecs[i].halt;
            ready = vecs[i].ready;
            redir = vecs[i].redir;
            rpc   = vecs[i].rpc;
            step();
            chk($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d pc_o", i), 32'(pco), 32'(vecs[i].pco));
            chk($sformatf("v%0d instr", i), instr, vecs[i].instr);
            chk($sformatf("v%0d addr", i), 32'(addr), 32'(vecs[i].addr));
`ifdef FETCH_PERF_EN
            if (i == 6)  chk("stall_before", scnt, 32'd0);
            if (i == 10) chk("stall_after4", scnt, 32'd4);
            if (i == 20) chk("fetch_total", fcnt, 32'd6);
            if (i == 20) chk("stall_total", scnt, 32'd8);
`endif
        end

        // mid-stream reset
        en = 1'b1; ready = 1'b1;
        step();
        step();
        chk("pre_rst valid", 32'(valid), 32'd1);
        chk("pre_rst pc_o", 32'(pco), 32'd64);
        chk("pre_rst instr", instr, 32'd6400);
        rst = 1'b1;
        step();
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst pc_o", 32'(pco), 32'd0);
        chk("rst instr", instr, 32'd0);
        chk("rst addr", 32'(addr), 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst fetch_cnt", fcnt, 32'd0);
        chk("rst stall_cnt", scnt, 32'd0);
`endif
        rst = 1'b0; en = 1'b0; ready = 1'b0;

        // 4-bit PC wrap
        s_rst = 1'b0; s_redir = 1'b1; s_rpc = 4'd15;
        step();
        chk("wrap redir addr", 32'(s_addr), 32'd15);
        chk("wrap redir valid", 32'(s_valid), 32'd0);
        s_redir = 1'b0; s_en = 1'b1;
        step();
        chk("wrap fetch valid", 32'(s_valid), 32'd0);
        step();
        chk("wrap pc15 valid", 32'(s_valid), 32'd1);
        chk("wrap pc15 pc_o", 32'(s_pco), 32'd15);
        chk("wrap pc15 instr", s_instr, 32'd1500);
        chk("wrap pc15 addr", 32'(s_addr), 32'd0);
        s_ready = 1'b1;
        step();
        chk("wrap pc0 pc_o", 32'(s_pco), 32'd0);
        chk("wrap pc0 instr", s_instr, 32'd0);
        chk("wrap pc0 addr", 32'(s_addr), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
